// File: rtl/pwm_divider_array_if.sv
// Duty-write channel between config logic and the PWM array: valid/ready request plus an error pulse.
interface pwm_divider_array_if #(
  parameter int CH_W  = 3,
  parameter int CNT_W = 8
) ();
  logic             cfg_valid;
  logic             cfg_ready;
  logic [CH_W-1:0]  cfg_ch;
  logic [CNT_W-1:0] cfg_duty;
  logic             cfg_err;

  modport master (output cfg_valid, cfg_ch, cfg_duty, input  cfg_ready, cfg_err);
  modport slave  (input  cfg_valid, cfg_ch, cfg_duty, output cfg_ready, cfg_err);
endinterface

// File: rtl/pwm_divider_array.sv
// Runtime-ratio prescaler driving CHANNEL double-buffered PWM lanes, single clock domain.
// Define PWM_CENTER_ALIGN_EN for an up/down (centre-aligned) PWM counter; default is edge-aligned up-count.
module pwm_divider_lane #(
  parameter int CNT_W = 8
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             enable,
  input  logic             reload,
  input  logic             wr_en,
  input  logic [CNT_W-1:0] wr_duty,
  input  logic [CNT_W-1:0] pwm_cnt,
  output logic             pwm_out
);
  logic [CNT_W-1:0] duty_stage_q, duty_stage_d;
  logic [CNT_W-1:0] duty_act_q, duty_act_d;
  logic             pwm_q, pwm_d;

  always_comb begin
    duty_stage_d = wr_en  ? wr_duty      : duty_stage_q;
    duty_act_d   = reload ? duty_stage_q : duty_act_q;
    pwm_d        = enable & (pwm_cnt < duty_act_q);
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      duty_stage_q <= '0;
      duty_act_q   <= '0;
      pwm_q        <= 1'b0;
    end else begin
      duty_stage_q <= duty_stage_d;
      duty_act_q   <= duty_act_d;
      pwm_q        <= pwm_d;
    end
  end

  assign pwm_out = pwm_q;
endmodule

module pwm_divider_array #(
  parameter int DIV_W   = 12,
  parameter int CNT_W   = 8,
  parameter int CHANNEL = 5,
  parameter int CH_W    = 3
) (
  input  logic               clk_in,
  input  logic               rst,
  input  logic               enable,
  input  logic [DIV_W-1:0]   div_value,
  input  logic [CNT_W-1:0]   period,
  pwm_divider_array_if.slave cfg,
  output logic               clk_div_out,
  output logic               period_start,
  output logic [CHANNEL-1:0] pwm_out
);
  logic [DIV_W-1:0] pre_cnt_q, pre_cnt_d, n_eff;
  logic [CNT_W-1:0] pwm_cnt_q, pwm_cnt_d, p_act_q, p_act_d, p_eff;
  logic             clk_div_q, clk_div_d;
  logic             period_start_q, period_start_d;
  logic             cfg_err_q, cfg_err_d;
  logic             tick, reload, at_top, accept, ch_ok;
`ifdef PWM_CENTER_ALIGN_EN
  logic             dir_q, dir_d;   // 0 = counting up, 1 = counting down
`endif

  always_comb begin
    n_eff  = (div_value == '0) ? DIV_W'(1) : div_value;
    p_eff  = (p_act_q == '0)   ? CNT_W'(1) : p_act_q;
    // >= rather than == so a ratio/period shrunk mid-count wraps at once
    tick   = enable & ~rst & (pre_cnt_q >= n_eff - DIV_W'(1));
    at_top = (pwm_cnt_q >= p_eff - CNT_W'(1));
`ifdef PWM_CENTER_ALIGN_EN
    reload = tick & dir_q & (pwm_cnt_q == '0);
`else
    reload = tick & at_top;
`endif
    accept    = cfg.cfg_valid & ~reload;
    ch_ok     = ({1'b0, cfg.cfg_ch} < (CH_W+1)'(CHANNEL));
    cfg_err_d = accept & ~ch_ok;

    pre_cnt_d = pre_cnt_q;
    if (tick)        pre_cnt_d = '0;
    else if (enable) pre_cnt_d = pre_cnt_q + DIV_W'(1);
    clk_div_d = enable & (pre_cnt_q < (n_eff >> 1));

    p_act_d        = reload ? period : p_act_q;
    period_start_d = reload;
    pwm_cnt_d      = pwm_cnt_q;
`ifdef PWM_CENTER_ALIGN_EN
    dir_d = dir_q;
    if (reload) begin
      pwm_cnt_d = '0;
      dir_d     = 1'b0;
    end else if (tick) begin
      if (!dir_q) begin
        // the top count is held for two ticks while turning round
        if (at_top) dir_d = 1'b1;
        else        pwm_cnt_d = pwm_cnt_q + CNT_W'(1);
      end else begin
        pwm_cnt_d = pwm_cnt_q - CNT_W'(1);
      end
    end
`else
    if (reload)    pwm_cnt_d = '0;
    else if (tick) pwm_cnt_d = pwm_cnt_q + CNT_W'(1);
`endif
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      pre_cnt_q      <= '0;
      pwm_cnt_q      <= '0;
      p_act_q        <= '0;
      clk_div_q      <= 1'b0;
      period_start_q <= 1'b0;
      cfg_err_q      <= 1'b0;
`ifdef PWM_CENTER_ALIGN_EN
      dir_q          <= 1'b0;
`endif
    end else begin
      pre_cnt_q      <= pre_cnt_d;
      pwm_cnt_q      <= pwm_cnt_d;
      p_act_q        <= p_act_d;
      clk_div_q      <= clk_div_d;
      period_start_q <= period_start_d;
      cfg_err_q      <= cfg_err_d;
`ifdef PWM_CENTER_ALIGN_EN
      dir_q          <= dir_d;
`endif
    end
  end

  for (genvar i = 0; i < CHANNEL; i++) begin : g_lane
    pwm_divider_lane #(.CNT_W(CNT_W)) u_lane (
      .clk_in  (clk_in),
      .rst     (rst),
      .enable  (enable),
      .reload  (reload),
      .wr_en   (accept & ch_ok & (cfg.cfg_ch == CH_W'(i))),
      .wr_duty (cfg.cfg_duty),
      .pwm_cnt (pwm_cnt_q),
      .pwm_out (pwm_out[i])
    );
  end

  assign cfg.cfg_ready = ~reload;
  assign cfg.cfg_err   = cfg_err_q;
  assign clk_div_out   = clk_div_q;
  assign period_start  = period_start_q;
endmodule

// File: tb/tb_pwm_divider_array.sv
// Randomised scoreboard bench for pwm_divider_array (edge-aligned build) with a few directed measurements.
module tb_pwm_divider_array;
  localparam int DIV_W = 12, CNT_W = 8, CHANNEL = 5, CH_W = 3;

  logic               clk_in = 1'b0;
  logic               rst = 1'b1, enable = 1'b0;
  logic [DIV_W-1:0]   div_value = 12'd1;
  logic [CNT_W-1:0]   period = 8'd10;
  logic               clk_div_out, period_start;
  logic [CHANNEL-1:0] pwm_out;

  pwm_divider_array_if #(.CH_W(CH_W), .CNT_W(CNT_W)) cfg ();

  pwm_divider_array #(.DIV_W(DIV_W), .CNT_W(CNT_W), .CHANNEL(CHANNEL), .CH_W(CH_W)) dut (
    .clk_in       (clk_in),
    .rst          (rst),
    .enable       (enable),
    .div_value    (div_value),
    .period       (period),
    .cfg          (cfg.slave),
    .clk_div_out  (clk_div_out),
    .period_start (period_start),
    .pwm_out      (pwm_out)
  );

  always #5 clk_in = ~clk_in;

  int errors = 0, checks = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t actual=%0h expected=%0h", nm, $time, act, exp);
    end
  endtask

  // Reference model: slot = position inside the current N-cycle prescale window,
  // pos = tick index inside the current PWM period of plen ticks.
  typedef struct {
    logic [CHANNEL-1:0] pwm;
    logic               cdiv;
    logic               ps;
    logic               err;
  } exp_t;
  exp_t exp_q[$];

  int slot = 0, pos = 0, plen = 0;
  int stage [CHANNEL];
  int act   [CHANNEL];

  function automatic int ratio();
    return (div_value == 0) ? 1 : int'(div_value);
  endfunction
  function automatic bit slot_end();
    return !rst && enable && (slot + 1 >= ratio());
  endfunction
  function automatic bit period_end();
    return slot_end() && (pos + 1 >= ((plen == 0) ? 1 : plen));
  endfunction

  initial begin : model
    exp_t e;
    bit se, pe, acc;
    for (int i = 0; i < CHANNEL; i++) begin stage[i] = 0; act[i] = 0; end
    forever begin
      @(posedge clk_in);
      se = slot_end();
      pe = period_end();
      acc = cfg.cfg_valid && !pe;
      e.cdiv = enable && (slot < ratio() / 2);
      for (int i = 0; i < CHANNEL; i++) e.pwm[i] = enable && (pos < act[i]);
      e.ps  = pe;
      e.err = acc && (int'(cfg.cfg_ch) >= CHANNEL);
      if (rst) begin
        e = '{pwm: '0, cdiv: 1'b0, ps: 1'b0, err: 1'b0};
        slot = 0; pos = 0; plen = 0;
        for (int i = 0; i < CHANNEL; i++) begin stage[i] = 0; act[i] = 0; end
      end else begin
        if (acc && int'(cfg.cfg_ch) < CHANNEL) stage[cfg.cfg_ch] = int'(cfg.cfg_duty);
        if (pe) begin
          pos = 0; plen = int'(period);
          for (int i = 0; i < CHANNEL; i++) act[i] = stage[i];
        end else if (se) pos++;
        if (se) slot = 0;
        else if (enable) slot++;
      end
      exp_q.push_back(e);
    end
  end

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk_in);
      chk("cfg_ready", cfg.cfg_ready, !period_end());
      if (exp_q.size() == 0) chk("sb_empty", 1, 0);
      else begin
        e = exp_q.pop_front();
        chk("pwm_out", pwm_out, e.pwm);
        chk("clk_div_out", clk_div_out, e.cdiv);
        chk("period_start", period_start, e.ps);
        chk("cfg_err", cfg.cfg_err, e.err);
      end
    end
  end

  task automatic cyc(input int k);
    repeat (k) begin @(posedge clk_in); #1; end
  endtask

  task automatic wr(input int ch, input int duty);
    bit r;
    cfg.cfg_valid = 1'b1; cfg.cfg_ch = CH_W'(ch); cfg.cfg_duty = CNT_W'(duty);
    for (int k = 0; k < 8; k++) begin
      r = cfg.cfg_ready;
      cyc(1);
      if (r) break;
    end
    cfg.cfg_valid = 1'b0;
  endtask

  task automatic wait_ps(input string nm);
    bit seen = 1'b0;
    for (int k = 0; k < 300 && !seen; k++) begin
      @(negedge clk_in);
      seen = period_start;
    end
    chk(nm, seen, 1);
  endtask

  int m_pwm [CHANNEL];
  int m_cd, m_ps;
  task automatic measure(input int k);
    for (int i = 0; i < CHANNEL; i++) m_pwm[i] = 0;
    m_cd = 0; m_ps = 0;
    repeat (k) begin
      @(negedge clk_in);
      for (int i = 0; i < CHANNEL; i++) m_pwm[i] += int'(pwm_out[i]);
      m_cd += int'(clk_div_out);
      m_ps += int'(period_start);
    end
    @(posedge clk_in); #1;
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog t=%0t simulation did not finish", $time);
    $fatal(1, "timeout");
  end

  initial begin : stim
    cfg.cfg_valid = 1'b0; cfg.cfg_ch = '0; cfg.cfg_duty = '0;
    cyc(3);
    chk("reset_ready", cfg.cfg_ready, 1);
    chk("reset_pwm", pwm_out, 0);
    rst = 1'b0;
    // duties staged while idle, applied at the first tick's reload
    wr(0, 0); wr(1, 3); wr(2, 10); wr(3, 15);
    enable = 1'b1;
    wait_ps("ps_first");
    measure(10);
    chk("s1_ch0_high", m_pwm[0], 0);
    chk("s1_ch1_high", m_pwm[1], 3);
    chk("s1_ch2_high", m_pwm[2], 10);
    chk("s1_ch3_high", m_pwm[3], 10);
    chk("s1_ps_count", m_ps, 1);

    div_value = 12'd3; period = 8'd4;
    cyc(40);
    measure(48);
    chk("n3_clkdiv_high", m_cd, 16);
    chk("n3_ps_count", m_ps, 4);
    div_value = 12'd4;
    cyc(40);
    measure(64);
    chk("n4_clkdiv_high", m_cd, 32);
    chk("n4_ps_count", m_ps, 4);

    div_value = 12'd1; period = 8'd10;
    wait_ps("ps_p10a"); wait_ps("ps_p10b");
    cyc(3);
    wr(1, 7);
    measure(4);
    chk("s3_ch1_old", m_pwm[1] <= 3, 1);
    wait_ps("ps_s3");
    measure(10);
    chk("s3_ch1_new", m_pwm[1], 7);

    wr(5, 9);
    wait_ps("ps_s5");
    measure(10);
    chk("s5_ch1_kept", m_pwm[1], 7);
    chk("s5_ch4_kept", m_pwm[4], 0);

    cyc(4);
    enable = 1'b0;
    cyc(20);
    chk("dis_pwm", pwm_out, 0);
    chk("dis_clkdiv", clk_div_out, 0);
    enable = 1'b1;
    cyc(5);
    rst = 1'b1;
    cyc(1);
    chk("rst_pwm", pwm_out, 0);
    chk("rst_ps", period_start, 0);
    rst = 1'b0;

    for (int k = 0; k < 3000; k++) begin
      cfg.cfg_valid = ($urandom_range(0, 3) == 0);
      cfg.cfg_ch    = CH_W'($urandom_range(0, 7));
      cfg.cfg_duty  = CNT_W'($urandom_range(0, 14));
      if ($urandom_range(0, 40) == 0)  div_value = DIV_W'($urandom_range(0, 5));
      if ($urandom_range(0, 30) == 0)  period = CNT_W'($urandom_range(0, 12));
      if ($urandom_range(0, 25) == 0)  enable = ~enable;
      rst = ($urandom_range(0, 400) == 0);
      cyc(1);
    end
    cfg.cfg_valid = 1'b0; rst = 1'b0;
    cyc(3);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
